// File: rtl/vagu_pkg.sv
// Shared types for the vector address-generation sequencer: FSM states,
// latched request record and the whole-register limit helper.
package vagu_pkg;

    localparam int PKG_ADDR_W = 16;
    localparam int PKG_OFF_W  = 16;
    localparam int PKG_REG_W  = 8;

    typedef enum logic {IDLE, RUN} state_t;

    // Fields are wide enough for any sane parameterisation; the top casts
    // them down to its own widths.
    typedef struct packed {
        logic [PKG_ADDR_W-1:0] base_a;
        logic [PKG_ADDR_W-1:0] base_b;
        logic [PKG_ADDR_W-1:0] base_d;
        logic [PKG_OFF_W-1:0]  max_off;
        logic [PKG_REG_W-1:0]  max_reg;
        logic                  widen;
    } vagu_req_t;

    typedef struct packed {
        logic [PKG_OFF_W-1:0] max_off;
        logic [PKG_REG_W-1:0] max_reg;
    } vagu_lim_t;

    function automatic vagu_lim_t whole_reg_lim(input int vlen, input int dw,
                                                input logic [1:0] sew);
        vagu_lim_t l;
        l.max_off = PKG_OFF_W'(vlen / dw - 1);
        l.max_reg = PKG_REG_W'((1 << sew) - 1);
        return l;
    endfunction

endpackage

// File: rtl/vagu_cnt.sv
// Offset/register wrap counter. Exposes the value it will hold after this
// cycle so the caller can register beat outputs from it directly.
module vagu_cnt #(
    parameter int OFF_WIDTH = 8,
    parameter int REG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [OFF_WIDTH-1:0] max_off,
    input  logic [REG_WIDTH-1:0] max_reg,
    output logic [OFF_WIDTH-1:0] nxt_off,
    output logic [REG_WIDTH-1:0] nxt_reg,
    output logic                 done
);

    logic [OFF_WIDTH-1:0] off;
    logic [REG_WIDTH-1:0] reg_idx;

    always_comb begin
        nxt_off = off;
        nxt_reg = reg_idx;
        if (clr) begin
            nxt_off = '0;
            nxt_reg = '0;
        end else if (en) begin
            if (off == max_off) begin
                nxt_off = '0;
                nxt_reg = reg_idx + REG_WIDTH'(1);
            end else begin
                nxt_off = off + OFF_WIDTH'(1);
            end
        end
    end

    // done flags that the upcoming position is the final one
    assign done = (nxt_off == max_off) && (nxt_reg == max_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            off     <= '0;
            reg_idx <= '0;
        end else begin
            off     <= nxt_off;
            reg_idx <= nxt_reg;
        end
    end

endmodule

// File: rtl/vagu_seq.sv
// Vector address-generation sequencer: expands one request into a stream of
// register/offset beats. Define VAGU_WIDEN_EN to enable widening mode.
module vagu_seq
    import vagu_pkg::*;
#(
    parameter int VLEN       = 16384,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8,
    parameter int REG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_sew,
    input  logic [OFF_WIDTH-1:0]  req_max_off,
    input  logic [REG_WIDTH-1:0]  req_max_reg,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [ADDR_WIDTH-1:0] req_addr_d,
    input  logic                  req_whole_reg,
    input  logic                  req_widen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr_a,
    output logic [ADDR_WIDTH-1:0] out_addr_b,
    output logic [ADDR_WIDTH-1:0] out_addr_d,
    output logic [OFF_WIDTH-1:0]  out_off_src,
    output logic [OFF_WIDTH-1:0]  out_off_dst,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);

    state_t    state_q, state_d;
    vagu_req_t req_q, cur;
    vagu_lim_t wl;

    logic hs, accept, load, src_en, last_nxt, src_done;
    logic [OFF_WIDTH-1:0] src_off, dst_off;
    logic [REG_WIDTH-1:0] src_reg;
    logic [REG_WIDTH:0]   dst_reg;

    assign hs        = out_valid & out_ready;
    assign req_ready = (state_q == IDLE) | (hs & out_last);
    assign accept    = req_valid & req_ready;
    assign load      = accept | (hs & ~out_last);
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);

    assign wl = whole_reg_lim(VLEN, DATA_WIDTH, req_sew);

    // On acceptance the new request drives the counters and beat-0 outputs
    // in the same cycle, which is what makes back-to-back bubble-free.
    always_comb begin
        cur = req_q;
        if (accept) begin
            cur.base_a  = PKG_ADDR_W'(req_addr_a);
            cur.base_b  = PKG_ADDR_W'(req_addr_b);
            cur.base_d  = PKG_ADDR_W'(req_addr_d);
            cur.max_off = req_whole_reg ? wl.max_off : PKG_OFF_W'(req_max_off);
            cur.max_reg = req_whole_reg ? wl.max_reg : PKG_REG_W'(req_max_reg);
            cur.widen   = req_widen & ~req_whole_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         req_q <= '0;
        else if (accept) req_q <= cur;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (hs & out_last & ~accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    vagu_cnt #(.OFF_WIDTH(OFF_WIDTH), .REG_WIDTH(REG_WIDTH)) u_src (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (src_en),
        .max_off (OFF_WIDTH'(cur.max_off)),
        .max_reg (REG_WIDTH'(cur.max_reg)),
        .nxt_off (src_off),
        .nxt_reg (src_reg),
        .done    (src_done)
    );

`ifdef VAGU_WIDEN_EN
    logic turn_q;
    logic dst_done;
    logic [REG_WIDTH:0] dst_max;

    // Widening: destination walks twice the registers, source every other beat
    assign src_en   = hs & (~cur.widen | turn_q);
    assign dst_max  = cur.widen ? {REG_WIDTH'(cur.max_reg), 1'b1}
                                : {1'b0, REG_WIDTH'(cur.max_reg)};
    assign last_nxt = cur.widen ? dst_done : src_done;

    always_ff @(posedge clk) begin
        if (rst || accept)        turn_q <= 1'b0;
        else if (hs && cur.widen) turn_q <= ~turn_q;
    end

    vagu_cnt #(.OFF_WIDTH(OFF_WIDTH), .REG_WIDTH(REG_WIDTH + 1)) u_dst (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (hs),
        .max_off (OFF_WIDTH'(cur.max_off)),
        .max_reg (dst_max),
        .nxt_off (dst_off),
        .nxt_reg (dst_reg),
        .done    (dst_done)
    );
`else
    assign src_en   = hs;
    assign last_nxt = src_done;
    assign dst_off  = src_off;
    assign dst_reg  = {1'b0, src_reg};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr_a  <= '0;
            out_addr_b  <= '0;
            out_addr_d  <= '0;
            out_off_src <= '0;
            out_off_dst <= '0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
        end else if (load) begin
            out_addr_a  <= ADDR_WIDTH'(cur.base_a + PKG_ADDR_W'(src_reg));
            out_addr_b  <= ADDR_WIDTH'(cur.base_b + PKG_ADDR_W'(src_reg));
            out_addr_d  <= ADDR_WIDTH'(cur.base_d + PKG_ADDR_W'(dst_reg));
            out_off_src <= src_off;
            out_off_dst <= dst_off;
            out_first   <= accept;
            out_last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_vagu_seq.sv
// Randomised self-checking bench for vagu_seq against a beat-list reference model.
module tb_vagu_seq;

    localparam int VLEN = 512;
    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int OW   = 8;
    localparam int RW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [1:0]    req_sew;
    logic [OW-1:0] req_max_off;
    logic [RW-1:0] req_max_reg;
    logic [AW-1:0] req_addr_a, req_addr_b, req_addr_d;
    logic          req_whole_reg, req_widen;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr_a, out_addr_b, out_addr_d;
    logic [OW-1:0] out_off_src, out_off_dst;
    logic          out_first, out_last, busy;

    vagu_seq #(.VLEN(VLEN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
               .OFF_WIDTH(OW), .REG_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sew(req_sew),
        .req_max_off(req_max_off), .req_max_reg(req_max_reg),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b), .req_addr_d(req_addr_d),
        .req_whole_reg(req_whole_reg), .req_widen(req_widen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr_a(out_addr_a), .out_addr_b(out_addr_b), .out_addr_d(out_addr_d),
        .out_off_src(out_off_src), .out_off_dst(out_off_dst),
        .out_first(out_first), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int b; int d; int os; int od;} beat_t;
    beat_t exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat k walks the destination linearly; the source position is k, or k/2 when widening.
    task automatic build(input int ba, input int bb, input int bd, input int mo,
                         input int mr, input bit whole, input int sew, input bit widen);
        int n, s;
        beat_t bt;
        exp_q.delete();
        if (whole) begin
            mo = VLEN / DW - 1;
            mr = (1 << sew) - 1;
            widen = 1'b0;
        end
`ifndef VAGU_WIDEN_EN
        widen = 1'b0;
`endif
        n = (mr + 1) * (mo + 1) * (widen ? 2 : 1);
        for (int k = 0; k < n; k++) begin
            s = widen ? k / 2 : k;
            bt.a  = (ba + s / (mo + 1)) % 32;
            bt.b  = (bb + s / (mo + 1)) % 32;
            bt.os = s % (mo + 1);
            bt.d  = (bd + k / (mo + 1)) % 32;
            bt.od = k % (mo + 1);
            exp_q.push_back(bt);
        end
    endtask

    task automatic issue(input int ba, input int bb, input int bd, input int mo,
                         input int mr, input bit whole, input int sew, input bit widen);
        int w = 0;
        build(ba, bb, bd, mo, mr, whole, sew, widen);
        req_addr_a = AW'(ba); req_addr_b = AW'(bb); req_addr_d = AW'(bd);
        req_max_off = OW'(mo); req_max_reg = RW'(mr);
        req_whole_reg = whole; req_sew = 2'(sew); req_widen = widen;
        req_valid = 1'b1;
        while (!req_ready && w < 100) begin tick(); w++; end
        chk("accept_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic check_beat(input int idx);
        chk("addr_a",  out_addr_a,  exp_q[idx].a);
        chk("addr_b",  out_addr_b,  exp_q[idx].b);
        chk("addr_d",  out_addr_d,  exp_q[idx].d);
        chk("off_src", out_off_src, exp_q[idx].os);
        chk("off_dst", out_off_dst, exp_q[idx].od);
        chk("first",   out_first,   idx == 0);
        chk("last",    out_last,    idx == exp_q.size() - 1);
    endtask

    // Consumes the expected beat list; a stalled beat is rechecked every cycle.
    task automatic drain(input int stall_pct, input int stall_at);
        int idx = 0;
        int cyc = 0;
        int st  = 0;
        while (idx < exp_q.size()) begin
            if (cyc >= 5000) begin chk("beat_timeout", idx, exp_q.size()); break; end
            if (idx == stall_at && st < 3) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            chk("valid", out_valid, 1);
            if (!out_valid) break;
            chk("busy", busy, 1);
            check_beat(idx);
            if (out_ready) idx++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy",  busy,      0);
        chk("idle_ready", req_ready, 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
        req_sew = '0; req_max_off = '0; req_max_reg = '0;
        req_addr_a = '0; req_addr_b = '0; req_addr_d = '0;
        req_whole_reg = 1'b0; req_widen = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy",  busy,      0);
        chk("rst_ready", req_ready, 1);
        chk("rst_first", out_first, 0);
        chk("rst_last",  out_last,  0);
        chk("rst_addr",  out_addr_a, 0);
        chk("rst_off",   out_off_src, 0);

        // basic 2x3 walk, then the same with a 3-cycle stall at beat 2
        issue(4, 7, 12, 2, 1, 0, 0, 0);
        drain(0, -1);
        issue(4, 7, 12, 2, 1, 0, 0, 0);
        drain(0, 2);

        // widening, and whole-register (sew=2 gives 4 regs x 8 beats)
        issue(2, 3, 8, 1, 0, 0, 0, 1);
        drain(0, -1);
        issue(16, 20, 24, 0, 0, 1, 2, 1);
        chk("whole_len",  exp_q.size(), 32);
        chk("whole_lasta", exp_q[31].a, 19);
        drain(0, -1);

        // back-to-back: second request accepted on the first one's last beat
        issue(3, 3, 3, 1, 0, 0, 0, 0);
        out_ready = 1'b1;
        check_beat(0);
        tick();
        check_beat(1);
        req_addr_a = 5'd10; req_addr_b = 5'd11; req_addr_d = 5'd12;
        req_max_off = '0; req_max_reg = '0; req_whole_reg = 1'b0; req_widen = 1'b0;
        req_valid = 1'b1;
        chk("b2b_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_addr",  out_addr_a, 10);
        chk("b2b_off",   out_off_src, 0);
        chk("b2b_first", out_first, 1);
        chk("b2b_last",  out_last, 1);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", out_valid, 0);

        // reset during beat 3 abandons the request
        issue(4, 7, 12, 2, 1, 0, 0, 0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("mid_addr", out_addr_a, 5);
        chk("mid_off",  out_off_src, 0);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        issue(9, 1, 30, 2, 1, 0, 0, 0);
        drain(0, -1);

        for (int i = 0; i < 20; i++) begin
            issue($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 1));
            drain(30, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
